// File: rtl/regfile_dump.sv
// Debug-side register file reader: walks x0..x(NUM_REGS-1) through a dedicated
// read port and streams (address, value) beats out over valid/ready.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Index is one bit wider than the address so the compare against the last
  // register can never wrap.
  localparam int FIRST_INT = SKIP_X0 ? 1 : 0;
  localparam int LAST_INT  = NUM_REGS - 1;
  localparam logic [ADDR_W:0] FIRST_IDX = FIRST_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_IDX  = LAST_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_IDX   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W:0]   index_reg, index_next;
  logic [ADDR_W:0]   index_plus;
  logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
  logic              out_valid_reg, out_valid_next;
  logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;

  assign index_plus = index_reg + ONE_IDX;

  // rf_addr is loaded on entry to READ so it already equals index during the
  // READ cycle and simply holds its value everywhere else.
  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    rf_addr_next   = rf_addr_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next   = ST_READ;
          index_next   = FIRST_IDX;
          rf_addr_next = FIRST_IDX[ADDR_W-1:0];
        end
      end
      ST_READ: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          out_data_next  = rf_data;
          out_addr_next  = index_reg[ADDR_W-1:0];
          out_valid_next = 1'b1;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        // abort wins over a handshake in the same cycle
        if (abort) begin
          state_next     = ST_IDLE;
          out_valid_next = 1'b0;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          if (index_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            index_next   = index_plus;
            rf_addr_next = index_plus[ADDR_W-1:0];
            state_next   = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      index_reg     <= FIRST_IDX;
      rf_addr_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      rf_addr_reg   <= rf_addr_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign rf_addr   = rf_addr_reg;
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: one instance walking from x0 and one
// skipping x0, both fed by a behavioural register file array.
module tb_regfile_dump;

  logic        clk;
  logic        rst;
  logic        start0, start1;
  logic        abort;
  logic        out_ready;
  logic [1:0]  busy_v, done_v, ov;
  logic [4:0]  rfa [2];
  logic [4:0]  oa  [2];
  logic [31:0] od  [2];
  logic [31:0] rfd [2];
  logic [31:0] rf_mem [32];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [4:0]  addr;
    logic [31:0] data;
    int          edge_n;   // handshake edge, -1 when timing is not predicted
    bit          aborted;  // beat is presented but must be dropped by abort
  } beat_t;

  typedef struct {
    int dut;
    int edge_n;
  } done_t;

  beat_t exp_q[$];
  done_t done_q[$];

  assign rfd[0] = rf_mem[rfa[0]];
  assign rfd[1] = rf_mem[rfa[1]];

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .busy(busy_v[0]), .done(done_v[0]), .rf_addr(rfa[0]), .rf_data(rfd[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_addr(oa[0]), .out_data(od[0])
  );

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .busy(busy_v[1]), .done(done_v[1]), .rf_addr(rfa[1]), .rf_data(rfd[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_addr(oa[1]), .out_data(od[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int d, output int e0);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    e0 = cyc + 1;
    wait_edge(cyc + 1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Expected beats for registers first..upto-1; with out_ready high register i
  // handshakes 2(i-first)+2 edges after start, plus any stall before it.
  task automatic push_beats(input int d, input int first, input int upto, input int e0,
                            input bit timed, input int stall_at, input int stall_len);
    for (int i = first; i < upto; i++) begin
      beat_t b;
      b.dut     = d;
      b.addr    = i[4:0];
      b.data    = (i == 0) ? 32'h0 : rf_mem[i];
      b.aborted = 1'b0;
      b.edge_n  = timed ? e0 + 2 * (i - first) + 2 + ((stall_at >= 0 && i >= stall_at) ? stall_len : 0) : -1;
      exp_q.push_back(b);
    end
  endtask

  task automatic push_done(input int d, input int edge_n);
    done_t x;
    x.dut    = d;
    x.edge_n = edge_n;
    done_q.push_back(x);
  endtask

  // Monitor: every presented beat is compared with the head of the queue; a
  // beat retires on handshake or on abort.
  always @(negedge clk) begin
    beat_t e;
    done_t dx;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat dut%0d: got addr=%0d data=%h, want none", d, oa[d], od[d]);
          end else begin
            e = exp_q[0];
            checks++;
            if (e.dut != d || oa[d] !== e.addr || od[d] !== e.data) begin
              errors++;
              $display("FAIL beat dut%0d: got addr=%0d data=%h, want dut%0d addr=%0d data=%h",
                       d, oa[d], od[d], e.dut, e.addr, e.data);
            end
            if (out_ready || abort) begin
              chk("beat_abort_outcome", {31'b0, abort}, {31'b0, e.aborted});
              if (!abort && e.edge_n >= 0) chk("beat_handshake_edge", cyc + 1, e.edge_n);
              void'(exp_q.pop_front());
            end
          end
        end
        if (done_v[d] === 1'b1) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: got done=1 want 0 (cycle %0d)", d, cyc);
          end else begin
            dx = done_q.pop_front();
            chk("done_dut", d, dx.dut);
            if (dx.edge_n >= 0) chk("done_edge", cyc, dx.edge_n);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;

    // Async reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", {31'b0, busy_v[d]}, 0);
      chk("reset_done", {31'b0, done_v[d]}, 0);
      chk("reset_out_valid", {31'b0, ov[d]}, 0);
      chk("reset_out_addr", {27'b0, oa[d]}, 0);
      chk("reset_out_data", od[d], 0);
      chk("reset_rf_addr", {27'b0, rfa[d]}, 0);
    end
    wait_edge(2);
    rst = 1'b0;
    wait_edge(cyc + 5);
    chk("idle_busy", {31'b0, busy_v[0]}, 0);
    chk("idle_out_valid", {31'b0, ov[0]}, 0);

    // Full dump, out_ready high
    do_start(0, e0);
    push_beats(0, 0, 32, e0, 1'b1, -1, 0);
    push_done(0, e0 + 64);
    wait_edge(e0 + 65);
    chk("full_busy_after", {31'b0, busy_v[0]}, 0);
    chk("full_done_after", {31'b0, done_v[0]}, 0);
    chk("full_drained", exp_q.size() + done_q.size(), 0);

    // Backpressure on x3 for 5 cycles plus an ignored start during x7
    do_start(0, e0);
    push_beats(0, 0, 32, e0, 1'b1, 3, 5);
    push_done(0, e0 + 69);
    wait_edge(e0 + 7);
    out_ready = 1'b0;
    wait_edge(e0 + 12);
    out_ready = 1'b1;
    wait_edge(e0 + 20);
    start0 = 1'b1;
    wait_edge(e0 + 21);
    start0 = 1'b0;
    wait_edge(e0 + 70);
    chk("bp_busy_after", {31'b0, busy_v[0]}, 0);
    chk("bp_drained", exp_q.size() + done_q.size(), 0);

    // Abort while x10 is being presented with out_ready high
    do_start(0, e0);
    push_beats(0, 0, 10, e0, 1'b1, -1, 0);
    begin
      beat_t b;
      b.dut = 0; b.addr = 5'd10; b.data = rf_mem[10]; b.edge_n = -1; b.aborted = 1'b1;
      exp_q.push_back(b);
    end
    wait_edge(e0 + 21);
    abort = 1'b1;
    wait_edge(e0 + 22);
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy_v[0]}, 0);
    chk("abort_out_valid", {31'b0, ov[0]}, 0);
    wait_edge(cyc + 3);
    chk("abort_drained", exp_q.size() + done_q.size(), 0);

    // Restart after abort with random contents and random backpressure
    for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
    do_start(0, e0);
    push_beats(0, 0, 32, e0, 1'b0, -1, 0);
    push_done(0, -1);
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      wait_edge(cyc + 1);
      n++;
    end
    out_ready = 1'b1;
    chk("random_completed", {31'b0, n < 3000}, 1);
    wait_edge(cyc + 1);
    chk("random_busy_after", {31'b0, busy_v[0]}, 0);

    // Async reset in the middle of the x20 beat
    do_start(0, e0);
    push_beats(0, 0, 20, e0, 1'b1, -1, 0);
    wait_edge(e0 + 41);
    #1 rst = 1'b1;
    #1;
    chk("midreset_busy", {31'b0, busy_v[0]}, 0);
    chk("midreset_done", {31'b0, done_v[0]}, 0);
    chk("midreset_out_valid", {31'b0, ov[0]}, 0);
    chk("midreset_out_addr", {27'b0, oa[0]}, 0);
    chk("midreset_out_data", od[0], 0);
    chk("midreset_rf_addr", {27'b0, rfa[0]}, 0);
    wait_edge(e0 + 43);
    rst = 1'b0;
    wait_edge(cyc + 2);
    chk("midreset_drained", exp_q.size() + done_q.size(), 0);

    // Instance that skips x0
    for (int i = 1; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i;
    do_start(1, e0);
    push_beats(1, 1, 32, e0, 1'b1, -1, 0);
    push_done(1, e0 + 62);
    wait_edge(e0 + 63);
    chk("skip_busy_after", {31'b0, busy_v[1]}, 0);

    wait_edge(cyc + 2);
    chk("final_beats_drained", exp_q.size(), 0);
    chk("final_done_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
